// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared encodings for the multicycle MIPS control path.
// Revision : 1.0
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JR        = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Brief    : Multicycle main control FSM: sequences each instruction and
//            drives all datapath enables, mux selects and alu_op.
// Revision : 1.0
// ============================================================================
module mc_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       jreg,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic       zero_ext,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;

    // The zero flag only reaches the PC through pc_write_cond in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RTYPE:         state_d = S_R_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = jreg ? S_JR : S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        zero_ext      = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        alu_op        = ALUOP_ADD;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                    OP_J, OP_ADDI, OP_ANDI: illegal_op = 1'b0;
                    default:                illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_op    = ALUOP_RTYPE;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
                zero_ext  = (opcode == OP_ANDI);
            end
            S_I_WB: begin
                reg_write = 1'b1;
                alu_op    = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
                zero_ext  = (opcode == OP_ANDI);
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_REGA;
            end
            default: ;
        endcase

        // Reset silences every enable at once, so an abandoned instruction
        // cannot complete a register or memory write.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            alu_src_a     = 1'b0;
            zero_ext      = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 2'b00;
            alu_op        = 3'b000;
            illegal_op    = 1'b0;
        end
    end

    assign state = rst ? 4'd0 : state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Brief    : Randomized scoreboard bench for mc_control.
// Revision : 1.0
// ============================================================================
module tb_mc_control;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, asa, zext;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
        logic ill;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       jreg = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a, zero_ext, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    ov_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .jreg(jreg), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src_a(alu_src_a), .zero_ext(zero_ext),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Monitor: compares every sampled output set against the oldest expectation.
    initial begin
        ov_t act, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, zero_ext,
                       alu_src_b, pc_source, alu_op, illegal_op};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL ctrl_outputs t=%0t exp_state=%0d got=%h expected=%h",
                             $time, e.st, act, e);
                end
            end
        end
    end

    function automatic ov_t blank(input int st);
        ov_t e;
        e = '0;
        e.st = st[3:0];
        return e;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {RT, LW, SW, BEQ, JMP, ADDI, ANDI};
    endfunction

    // One clock of stimulus plus the response the datapath should see.
    task automatic cyc(input bit r, input bit r_mid, input bit mr, input bit jr,
                       input logic [5:0] op, input ov_t e);
        @(posedge clk);
        #1;
        rst = r;
        mem_ready = mr;
        jreg = jr;
        opcode = op;
        zero = 1'($urandom);
        exp_q.push_back(e);
        if (r_mid) begin
            #1 rst = 1'b1;
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic do_fetch(input int fstall);
        ov_t e;
        for (int i = 0; i < fstall; i++) begin
            e = blank(0); e.mrd = 1; e.asb = 2'b01;
            cyc(0, 0, 0, rb(), 6'($urandom), e);
        end
        e = blank(0); e.mrd = 1; e.asb = 2'b01; e.irw = 1; e.pcw = 1;
        cyc(0, 0, 1, rb(), 6'($urandom), e);
    endtask

    // Whole-instruction model: the cycle list follows from the opcode class,
    // the jr choice and how many cycles memory stalls.
    task automatic issue(input logic [5:0] op, input bit is_jr, input int fstall,
                         input int mstall);
        ov_t e;
        do_fetch(fstall);
        e = blank(1); e.asb = 2'b11; e.ill = !is_legal(op);
        cyc(0, 0, rb(), rb(), op, e);
        if (!is_legal(op)) return;
        case (op)
            LW, SW: begin
                e = blank(2); e.asa = 1; e.asb = 2'b10;
                cyc(0, 0, rb(), rb(), op, e);
                e = blank(op == LW ? 3 : 5); e.iord = 1;
                if (op == LW) e.mrd = 1; else e.mwr = 1;
                for (int i = 0; i < mstall; i++) cyc(0, 0, 0, rb(), op, e);
                cyc(0, 0, 1, rb(), op, e);
                if (op == LW) begin
                    e = blank(4); e.rw = 1; e.m2r = 1;
                    cyc(0, 0, rb(), rb(), op, e);
                end
            end
            RT: begin
                e = blank(6); e.asa = 1; e.aop = 3'b100;
                cyc(0, 0, rb(), is_jr, op, e);
                if (is_jr) begin
                    e = blank(12); e.pcw = 1; e.pcs = 2'b11;
                end else begin
                    e = blank(7); e.rw = 1; e.rdst = 1; e.aop = 3'b100;
                end
                cyc(0, 0, rb(), rb(), op, e);
            end
            BEQ: begin
                e = blank(8); e.asa = 1; e.aop = 3'b001; e.pcwc = 1; e.pcs = 2'b01;
                cyc(0, 0, rb(), rb(), op, e);
            end
            JMP: begin
                e = blank(9); e.pcw = 1; e.pcs = 2'b10;
                cyc(0, 0, rb(), rb(), op, e);
            end
            default: begin
                e = blank(10); e.asa = 1; e.asb = 2'b10;
                e.aop = (op == ANDI) ? 3'b011 : 3'b000; e.zext = (op == ANDI);
                cyc(0, 0, rb(), rb(), op, e);
                e = blank(11); e.rw = 1;
                e.aop = (op == ANDI) ? 3'b011 : 3'b000; e.zext = (op == ANDI);
                cyc(0, 0, rb(), rb(), op, e);
            end
        endcase
    endtask

    // lw interrupted by an asynchronous reset during MEM_WB.
    task automatic lw_with_reset();
        ov_t e;
        do_fetch(0);
        e = blank(1); e.asb = 2'b11;
        cyc(0, 0, 1, 0, LW, e);
        e = blank(2); e.asa = 1; e.asb = 2'b10;
        cyc(0, 0, 1, 0, LW, e);
        e = blank(3); e.mrd = 1; e.iord = 1;
        cyc(0, 0, 1, 0, LW, e);
        cyc(0, 1, 1, 0, LW, blank(0));
        cyc(1, 0, 1, 0, LW, blank(0));
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [7];
        ops = '{RT, LW, SW, BEQ, JMP, ADDI, ANDI};
        case ($urandom_range(0, 8))
            7: return 6'h3f;
            8: return 6'($urandom);
            default: return ops[$urandom_range(0, 6)];
        endcase
    endfunction

    initial begin
        int guard;
        cyc(1, 0, 1, 0, 6'd0, blank(0));
        cyc(1, 0, 1, 0, 6'd0, blank(0));
        lw_with_reset();
        issue(LW,   0, 0, 0);
        issue(RT,   0, 0, 0);
        issue(RT,   1, 0, 0);
        issue(BEQ,  0, 0, 0);
        issue(JMP,  0, 0, 0);
        issue(SW,   0, 2, 3);
        issue(ANDI, 0, 0, 0);
        issue(ADDI, 0, 1, 0);
        issue(6'h3f, 0, 0, 0);
        lw_with_reset();
        for (int n = 0; n < 300; n++) begin
            issue(rand_op(), rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS datapath. It decodes the instruction opcode and sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable and mux select, and produces the 3-bit `alu_op` consumed by `alu_control`. It takes `jreg` back from `alu_control` to redirect `jr` instructions.

## Interface
- Parameters: none. Encodings are fixed constants in the shared package.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26]; stable from DECODE until the instruction's last state.
- `jreg` in 1: from `alu_control`; valid in R_EXEC.
- `zero` in 1: ALU zero flag. Used only through the `pc_write_cond` gating in the datapath.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_write`, `reg_dst`, `alu_src_a`, `zero_ext` out 1 each: datapath enables and selects.
- `alu_src_b` out 2: 00 = reg B, 01 = constant 4, 10 = immediate, 11 = immediate<<2.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target, 11 = reg A (jr).
- `alu_op` out 3: 000 = add, 001 = sub, 011 = and, 100 = R-type (funct decides).
- `illegal_op` out 1: unsupported opcode seen in DECODE.
- `state` out 4: current state, for debug.

## Operation
Supported opcodes:
- R-type 000000: add, sub, sll, nor, and, slt, jr.
- lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100.

States, 4-bit encoding. Outputs not listed in a state are 0, and `alu_op` defaults to 000.
- FETCH (0): `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE (1): `alu_src_b`=11, `alu_op`=000 (precompute branch target). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R-type → R_EXEC
  - beq → BRANCH
  - j → JUMP
  - addi/andi → I_EXEC
  - anything else → FETCH, with `illegal_op`=1 during this DECODE cycle.
- MEM_ADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ (3): `mem_read`=1, `i_or_d`=1. Stay while `mem_ready`=0; then → MEM_WB.
- MEM_WB (4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. → FETCH.
- MEM_WRITE (5): `mem_write`=1, `i_or_d`=1. Stay while `mem_ready`=0; then → FETCH.
- R_EXEC (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=100. `jreg`=1 → JR; otherwise → R_WB.
- R_WB (7): `reg_write`=1, `reg_dst`=1, `alu_op`=100. → FETCH.
- BRANCH (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_write_cond`=1, `pc_source`=01. → FETCH.
- JUMP (9): `pc_write`=1, `pc_source`=10. → FETCH.
- I_EXEC (10): `alu_src_a`=1, `alu_src_b`=10.
  - addi: `alu_op`=000, `zero_ext`=0.
  - andi: `alu_op`=011, `zero_ext`=1.
  - → I_WB, holding the same `alu_op` and `zero_ext` values.
- I_WB (11): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. → FETCH.
- JR (12): `pc_write`=1, `pc_source`=11. → FETCH.
- Encodings 13–15 are unreachable; if entered, next state is FETCH and all outputs are 0.

## Timing
- `state` is registered; all other outputs are combinational from `state`, `opcode`, `mem_ready` and `jreg`.
- Reset:
  - `rst`=1 forces state FETCH immediately, without waiting for a clock edge.
  - While `rst`=1, every output is forced to 0, including `mem_read`, `pc_write` and `ir_write`.
  - Reset asserted mid-instruction abandons that instruction; no further register or memory write occurs.
  - The first fetch starts on the first rising edge after `rst` falls.
- Cycle counts with `mem_ready` held at 1:
  - lw: 5 (FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB).
  - sw: 4.
  - R-type: 4.
  - jr: 4 (FETCH, DECODE, R_EXEC, JR).
  - addi/andi: 4.
  - beq: 3.
  - j: 3.
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
  - During a stall, `pc_write`, `ir_write` and `reg_write` stay 0.
  - `mem_read` / `mem_write` stay asserted throughout the stall.
- `jreg` is sampled only in R_EXEC; it is ignored in every other state.
- `opcode` is sampled in DECODE, MEM_ADDR and I_EXEC. It must not change until FETCH; `ir_write` is 0 outside FETCH, so the IR holds it.

## Structure
- Shared package `mips_ctrl_pkg`:
  - state enum (4-bit) with the encodings above;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI);
  - `alu_op` constants (ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_AND=011, ALUOP_RTYPE=100);
  - `alu_src_b` and `pc_source` select constants.
- `alu_control` imports the same `alu_op` constants.
- Single module: one state register, one next-state block and one output-decode block. No sub-module is needed.

## Test plan
- Reset: assert `rst` asynchronously mid-MEM_WB of an lw → `state`=0 and `reg_write`=0 in the same cycle. After release, FETCH asserts `mem_read`=1.
- lw, `mem_ready`=1: `state` sequence 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in cycle 5. `pc_write`=1 only in cycle 1.
- R-type add, then jr (`jreg`=1 in R_EXEC):
  - add: states 0,1,6,7 with `alu_op`=100 in 6 and 7.
  - jr: states 0,1,6,12 with `pc_source`=11, `pc_write`=1 and `reg_write` never 1.
- beq: states 0,1,8 with `alu_op`=001, `pc_write_cond`=1, `pc_source`=01. j: states 0,1,9 with `pc_source`=10.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write`=1 for 4 cycles, then FETCH. A fetch stall of 2 cycles → `ir_write` pulses once.
- andi → I_EXEC has `alu_op`=011 and `zero_ext`=1. Opcode 111111 → `illegal_op`=1 for one DECODE cycle, then FETCH with no writes.
